memory_arbiter: RTL and testbench

Single-ported RAM arbiter that sits directly upstream of the pipeline hazard unit. It accepts instruction-fetch and data-memory requests and serializes them onto one RAM port. It returns load data and produces the one-cycle `ihit`/`dhit` pulses that the hazard unit uses to enable or stall pipeline stages. A sticky error flag records RAM timeouts.

---
 rtl/memory_arbiter.sv | 153 +++++++++++++++
 tb/tb_memory_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: serializes instruction-fetch and data requests onto one RAM port,
// returns load data with one-cycle ihit/dhit pulses, and records RAM timeouts in a sticky flag.
module memory_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        merr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    IACC,
    DACC,
    IDONE,
    DDONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic          wsel_q, wsel_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic          merr_q, merr_d;
  logic          last_data_q, last_data_d;

  logic ipend, dpend, grant_d, grant_i;

  assign ipend   = iREN;
  assign dpend   = dREN | dWEN;
  // On a tie, the side that was not served last wins; data wins the first tie after reset.
  assign grant_d = dpend & (~ipend | ~last_data_q);
  assign grant_i = ipend & ~grant_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    store_d     = store_q;
    wsel_d      = wsel_q;
    iload_d     = iload_q;
    dload_d     = dload_q;
    merr_d      = merr_q;
    last_data_d = last_data_q;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wsel_d  = dWEN;
          cnt_d   = '0;
        end else if (grant_i) begin
          state_d = IACC;
          addr_d  = iaddr;
          store_d = '0;
          wsel_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      IACC, DACC: begin
        // A ready arriving on the same cycle the counter expires is still a success.
        if (ramready) begin
          state_d = (state_q == IACC) ? IDONE : DDONE;
          if (state_q == IACC)  iload_d = ramload;
          else if (!wsel_q)     dload_d = ramload;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = (state_q == IACC) ? IDONE : DDONE;
          merr_d  = 1'b1;
          if (state_q == IACC)  iload_d = ERR_WORD;
          else if (!wsel_q)     dload_d = ERR_WORD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      IDONE: begin
        last_data_d = 1'b0;
        state_d     = IDLE;
      end

      DDONE: begin
        last_data_d = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      store_q     <= '0;
      wsel_q      <= 1'b0;
      iload_q     <= '0;
      dload_q     <= '0;
      merr_q      <= 1'b0;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      wsel_q      <= wsel_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      merr_q      <= merr_d;
      last_data_q <= last_data_d;
    end
  end

  // RAM strobes decode purely from registered state, so they drop the moment reset asserts.
  assign ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wsel_q);
  assign ramWEN   = (state_q == DACC) & wsel_q;
  assign ramaddr  = ((state_q == IACC) | (state_q == DACC)) ? addr_q : '0;
  assign ramstore = (state_q == DACC) ? store_q : '0;
  assign ihit     = (state_q == IDONE);
  assign dhit     = (state_q == DDONE);
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign merr     = merr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: each task walks a scenario cycle by cycle against
// hand-computed expectations.
module tb_memory_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        merr;

  int n_checks = 0;
  int n_fail   = 0;

  memory_arbiter #(.TIMEOUT(TIMEOUT), .ERR_WORD(32'hDEADBEEF)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .merr(merr)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs sampled 2 time units after each rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    next_cycle();
    next_cycle();
    nRST = 1'b0;
  endtask

  task automatic test_reset();
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramready = 0;
    nRST = 1'b1;
    #1;
    n_checks++;
    if ({ihit, dhit, ramREN, ramWEN, merr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {ihit, dhit, ramREN, ramWEN, merr});
    end
    n_checks++;
    if (iload !== 32'h0 || dload !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_loads: got iload=%h dload=%h expected 0", iload, dload);
    end
    n_checks++;
    if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ram_bus: got addr=%h store=%h expected 0", ramaddr, ramstore);
    end
    next_cycle();
    nRST = 1'b0;
  endtask

  task automatic test_ifetch();
    iREN = 1; iaddr = 32'h0000_0040;
    next_cycle();  // cycle 1
    ramready = 1; ramload = 32'h2002_0002;
    n_checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL ifetch_acc: got ren=%b wen=%b addr=%h expected 1 0 00000040", ramREN, ramWEN, ramaddr);
    end
    next_cycle();  // cycle 2
    ramready = 0;
    n_checks++;
    if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h2002_0002 || ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL ifetch_hit: got ihit=%b dhit=%b iload=%h ren=%b expected 1 0 20020002 0", ihit, dhit, iload, ramREN);
    end
    iREN = 0;
    next_cycle();  // cycle 3, IDLE
    n_checks++;
    if (ihit !== 1'b0 || iload !== 32'h2002_0002) begin
      n_fail++;
      $display("FAIL ifetch_after: got ihit=%b iload=%h expected 0 20020002", ihit, iload);
    end
  endtask

  task automatic test_write();
    dWEN = 1; daddr = 32'h100; dstore = 32'hCAFE_F00D; ramload = 32'h7777_7777;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      ramready = (c == 4);
      n_checks++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hCAFE_F00D || ramaddr !== 32'h100 || dhit !== 1'b0) begin
        n_fail++;
        $display("FAIL write_acc c%0d: got wen=%b ren=%b store=%h addr=%h dhit=%b expected 1 0 cafef00d 00000100 0",
                 c, ramWEN, ramREN, ramstore, ramaddr, dhit);
      end
    end
    next_cycle();  // cycle 5
    ramready = 0;
    n_checks++;
    if (dhit !== 1'b1 || ramWEN !== 1'b0 || dload !== 32'h0 || ramstore !== 32'h0) begin
      n_fail++;
      $display("FAIL write_hit: got dhit=%b wen=%b dload=%h store=%h expected 1 0 0 0", dhit, ramWEN, dload, ramstore);
    end
    dWEN = 0;
    next_cycle();
  endtask

  task automatic test_arbitration();
    logic exp_dhit, exp_ihit, exp_ren;
    logic [31:0] exp_addr;
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h200;
    ramready = 1; ramload = 32'h1357_9BDF;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c == 12) begin
        iREN = 0; dREN = 0;
      end
      exp_dhit = (c % 6 == 2);
      exp_ihit = (c % 6 == 5);
      exp_ren  = (c % 3 == 1);
      exp_addr = (c % 6 == 1) ? 32'h200 : (c % 6 == 4) ? 32'h40 : 32'h0;
      n_checks++;
      if (dhit !== exp_dhit || ihit !== exp_ihit || ramREN !== exp_ren || ramaddr !== exp_addr) begin
        n_fail++;
        $display("FAIL arb c%0d: got dhit=%b ihit=%b ren=%b addr=%h expected %b %b %b %h",
                 c, dhit, ihit, ramREN, ramaddr, exp_dhit, exp_ihit, exp_ren, exp_addr);
      end
    end
    n_checks++;
    if (iload !== 32'h1357_9BDF || dload !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL arb_loads: got iload=%h dload=%h expected 13579bdf", iload, dload);
    end
    next_cycle();
  endtask

  task automatic test_ready_at_limit();
    dREN = 1; daddr = 32'h280; ramready = 0; ramload = 32'h1234_5678;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      next_cycle();
      ramready = (c == TIMEOUT + 1);
    end
    next_cycle();  // cycle TIMEOUT+2
    ramready = 0;
    n_checks++;
    if (dhit !== 1'b1 || dload !== 32'h1234_5678 || merr !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_at_limit: got dhit=%b dload=%h merr=%b expected 1 12345678 0", dhit, dload, merr);
    end
    dREN = 0;
    next_cycle();
  endtask

  task automatic test_timeout();
    dREN = 1; daddr = 32'h300; ramready = 0; ramload = 32'h0;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      next_cycle();
      if (c == 1 || c == TIMEOUT + 1) begin
        n_checks++;
        if (ramREN !== 1'b1 || dhit !== 1'b0 || merr !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_acc c%0d: got ren=%b dhit=%b merr=%b expected 1 0 0", c, ramREN, dhit, merr);
        end
      end
    end
    next_cycle();  // cycle 18
    n_checks++;
    if (dhit !== 1'b1 || dload !== 32'hDEADBEEF || merr !== 1'b1 || ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hit: got dhit=%b dload=%h merr=%b ren=%b expected 1 deadbeef 1 0", dhit, dload, merr, ramREN);
    end
    dREN = 0;
    next_cycle();
    // A good fetch afterwards leaves the flag set.
    iREN = 1; iaddr = 32'h44;
    next_cycle();
    ramready = 1; ramload = 32'hA5A5_0001;
    next_cycle();
    ramready = 0;
    n_checks++;
    if (ihit !== 1'b1 || iload !== 32'hA5A5_0001 || merr !== 1'b1) begin
      n_fail++;
      $display("FAIL merr_sticky: got ihit=%b iload=%h merr=%b expected 1 a5a50001 1", ihit, iload, merr);
    end
    iREN = 0;
    next_cycle();
    do_reset();
    n_checks++;
    if (merr !== 1'b0) begin
      n_fail++;
      $display("FAIL merr_reset: got %b expected 0", merr);
    end
  endtask

  task automatic test_addr_hold();
    dREN = 1; daddr = 32'h400; ramready = 0;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      daddr = 32'h999 + c; dstore = 32'hFFFF_0000;
      ramready = (c == 3); ramload = 32'h0BAD_F00D;
      n_checks++;
      if (ramaddr !== 32'h400 || ramREN !== 1'b1) begin
        n_fail++;
        $display("FAIL addr_hold c%0d: got addr=%h ren=%b expected 00000400 1", c, ramaddr, ramREN);
      end
    end
    next_cycle();
    ramready = 0;
    n_checks++;
    if (dhit !== 1'b1 || dload !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL addr_hold_hit: got dhit=%b dload=%h expected 1 0badf00d", dhit, dload);
    end
    dREN = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    dREN = 1; daddr = 32'h500; ramready = 0;
    next_cycle();  // cycle 1
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
      n_fail++;
      $display("FAIL rst_mid_acc: got ren=%b addr=%h expected 1 00000500", ramREN, ramaddr);
    end
    next_cycle();  // cycle 2, still waiting
    nRST = 1'b1;
    #1;
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got ren=%b wen=%b addr=%h expected 0 0 0", ramREN, ramWEN, ramaddr);
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      n_checks++;
      if (dhit !== 1'b0 || ramREN !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_nohit: got dhit=%b ren=%b expected 0 0", dhit, ramREN);
      end
    end
    nRST = 1'b0;
    ramready = 1; ramload = 32'h55AA_1234;
    next_cycle();  // cycle 1 of the re-arbitrated request
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
      n_fail++;
      $display("FAIL rst_retry_acc: got ren=%b addr=%h expected 1 00000500", ramREN, ramaddr);
    end
    next_cycle();
    ramready = 0;
    n_checks++;
    if (dhit !== 1'b1 || dload !== 32'h55AA_1234) begin
      n_fail++;
      $display("FAIL rst_retry_hit: got dhit=%b dload=%h expected 1 55aa1234", dhit, dload);
    end
    dREN = 0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_write();
    test_arbitration();
    test_ready_at_limit();
    test_timeout();
    test_addr_hold();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
